// File: rtl/encoder_8to3.sv
// encoder_8to3: registered 8-to-3 priority encoder with valid flag.
// The highest-numbered set bit of the request vector wins. The result is
// captured on enabled clock edges and held otherwise.
//
// Optional feature macro: ENCODER_8TO3_MULTIHOT_EN
//   When defined, adds a registered `multi` output that flags captured
//   vectors with two or more bits set.
//
// Ports:
//   clk    in   1  clock, rising edge
//   rst    in   1  asynchronous active-high reset
//   en     in   1  capture enable (0 = hold outputs)
//   a      in   8  request vector
//   b      out  4  {valid, index of highest set bit}
//   multi  out  1  more than one bit of captured `a` set (macro builds only)
module encoder_8to3 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] a,
`ifdef ENCODER_8TO3_MULTIHOT_EN
    output logic [3:0] b,
    output logic       multi
`else
    output logic [3:0] b
`endif
);

    localparam int unsigned IN_W  = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned OUT_W = IDX_W + 1;

    logic [IDX_W-1:0] index_c;
    logic             valid_c;
    logic [OUT_W-1:0] enc_c;

    // Ascending scan: the last set bit seen is the highest, so it wins.
    always_comb begin
        index_c = '0;
        for (int i = 0; i < int'(IN_W); i++) begin
            if (a[i]) begin
                index_c = IDX_W'(i);
            end
        end
        valid_c = |a;
        enc_c   = {valid_c, index_c};
    end

    // Result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b <= '0;
        end else if (en) begin
            b <= enc_c;
        end
    end

`ifdef ENCODER_8TO3_MULTIHOT_EN
    logic multi_c;

    // Clearing the lowest set bit leaves something only if two or more were set.
    always_comb begin
        multi_c = |(a & (a - IN_W'(1)));
    end

    // Multi-hot flag register, same enable and reset as the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            multi <= 1'b0;
        end else if (en) begin
            multi <= multi_c;
        end
    end
`endif

endmodule

// File: tb/tb_encoder_8to3.sv
// tb_encoder_8to3: scoreboard bench for encoder_8to3.
// Stimulus drives inputs on the falling edge and queues expected results for
// enabled edges. A monitor checks every clock edge and every reset assertion.
module tb_encoder_8to3;

    typedef struct packed {
        logic [3:0] b;
        logic       multi;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] a;
    logic [3:0] b;
`ifdef ENCODER_8TO3_MULTIHOT_EN
    logic       multi;
`endif

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    exp_t exp_hold;

    always #5 clk = ~clk;

    encoder_8to3 dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .a     (a),
`ifdef ENCODER_8TO3_MULTIHOT_EN
        .b     (b),
        .multi (multi)
`else
        .b     (b)
`endif
    );

    // Reference model: scan from the top down for the first set bit.
    function automatic exp_t model(input logic [7:0] v);
        exp_t r;
        int   ones;
        r    = '0;
        ones = 0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                ones++;
                if (r.b[3] == 1'b0) begin
                    r.b = {1'b1, 3'(i)};
                end
            end
        end
        r.multi = (ones >= 2);
        return r;
    endfunction

    task automatic compare(input string name, input exp_t exp);
        checks++;
        if (b !== exp.b) begin
            errors++;
            $display("FAIL %s: b=%b expected %b (t=%0t)", name, b, exp.b, $time);
        end
`ifdef ENCODER_8TO3_MULTIHOT_EN
        checks++;
        if (multi !== exp.multi) begin
            errors++;
            $display("FAIL %s: multi=%b expected %b (t=%0t)", name, multi, exp.multi, $time);
        end
`endif
    endtask

    // Monitor: pops on enabled edges, checks hold on disabled edges, zero under reset.
    initial begin
        logic en_s;
        exp_hold = '0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                exp_hold = '0;
                #1;
                compare("reset", '0);
            end else begin
                en_s = en;
                #1;
                if (en_s) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL underflow: enabled edge with no expected entry (t=%0t)", $time);
                    end else begin
                        exp_hold = exp_q.pop_front();
                        compare("capture", exp_hold);
                    end
                end else begin
                    compare("hold", exp_hold);
                end
            end
        end
    end

    task automatic drive(input logic [7:0] av, input logic env,
                         input logic [3:0] eb, input logic em);
        exp_t e;
        @(negedge clk);
        a  = av;
        en = env;
        if (env) begin
            e.b     = eb;
            e.multi = em;
            exp_q.push_back(e);
        end
    endtask

    // Reset pulse placed between edges, after the previous sample has appeared.
    task automatic mid_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
    endtask

    initial begin
        exp_t m;
        rst = 1'b1;
        en  = 1'b0;
        a   = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Zero input after release.
        drive(8'h00, 1'b1, 4'b0000, 1'b0);

        // Every one-hot value.
        drive(8'h01, 1'b1, 4'b1000, 1'b0);
        drive(8'h02, 1'b1, 4'b1001, 1'b0);
        drive(8'h04, 1'b1, 4'b1010, 1'b0);
        drive(8'h08, 1'b1, 4'b1011, 1'b0);
        drive(8'h10, 1'b1, 4'b1100, 1'b0);
        drive(8'h20, 1'b1, 4'b1101, 1'b0);
        drive(8'h40, 1'b1, 4'b1110, 1'b0);
        drive(8'h80, 1'b1, 4'b1111, 1'b0);

        // Multi-hot priority.
        drive(8'b0001_1100, 1'b1, 4'b1100, 1'b1);
        drive(8'hFF,        1'b1, 4'b1111, 1'b1);
        drive(8'h03,        1'b1, 4'b1001, 1'b1);

        // Enable hold.
        drive(8'h08, 1'b1, 4'b1011, 1'b0);
        drive(8'h40, 1'b0, 4'b0000, 1'b0);
        drive(8'h40, 1'b0, 4'b0000, 1'b0);
        drive(8'h40, 1'b0, 4'b0000, 1'b0);
        drive(8'h40, 1'b1, 4'b1110, 1'b0);

        // Async reset with b nonzero, then outputs stay clear until an enabled edge.
        drive(8'h80, 1'b1, 4'b1111, 1'b0);
        mid_reset();
        drive(8'h80, 1'b0, 4'b0000, 1'b0);
        drive(8'h80, 1'b1, 4'b1111, 1'b0);

        // Mid-stream reset while streaming one-hot values.
        drive(8'h10, 1'b1, 4'b1100, 1'b0);
        drive(8'h20, 1'b1, 4'b1101, 1'b0);
        mid_reset();
        drive(8'h02, 1'b1, 4'b1001, 1'b0);
        drive(8'h04, 1'b1, 4'b1010, 1'b0);

        // Exhaustive sweep against the reference model.
        for (int i = 0; i < 256; i++) begin
            m = model(8'(i));
            drive(8'(i), 1'b1, m.b, m.multi);
        end

        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
